// File: rtl/minterm_scanner.sv
// Sequential truth-table reader: steps a 3-input function block through all
// eight input combinations, samples its output and compares against EXPECTED.
module minterm_scanner #(
    parameter logic [7:0] EXPECTED = 8'hD5,
    parameter int         SETTLE   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       f_in,
    output logic [2:0] abc_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] mask,
    output logic       match,
    output logic [2:0] err_idx
);
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state, state_nxt;
    logic [2:0] idx, idx_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [7:0] shadow, shadow_nxt;
    logic       finish;

    // Lowest set bit of d, 0 when d is all zero.
    function automatic logic [2:0] first_diff(input logic [7:0] d);
        first_diff = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (d[i]) first_diff = 3'(i);
    endfunction

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        cnt_nxt    = cnt;
        shadow_nxt = shadow;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt  = DRIVE;
                    idx_nxt    = 3'd0;
                    cnt_nxt    = 4'd0;
                    shadow_nxt = 8'h00;
                end
            end
            DRIVE: begin
                cnt_nxt = cnt + 4'd1;
                if (cnt == SETTLE_LAST) state_nxt = SAMPLE;
            end
            SAMPLE: begin
                shadow_nxt[idx] = f_in;
                if (idx == 3'd7) begin
                    state_nxt = DONE;
                    finish    = 1'b1;
                end else begin
                    state_nxt = DRIVE;
                    idx_nxt   = idx + 3'd1;
                    cnt_nxt   = 4'd0;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= 3'd0;
            cnt     <= 4'd0;
            shadow  <= 8'h00;
            mask    <= 8'h00;
            match   <= (EXPECTED == 8'h00);
            err_idx <= first_diff(EXPECTED);
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            cnt    <= cnt_nxt;
            shadow <= shadow_nxt;
            // Result registers only move on the edge entering DONE.
            if (finish) begin
                mask    <= shadow_nxt;
                match   <= (shadow_nxt == EXPECTED);
                err_idx <= first_diff(shadow_nxt ^ EXPECTED);
            end
        end
    end

    assign busy    = (state == DRIVE) || (state == SAMPLE);
    assign done    = (state == DONE);
    assign abc_out = busy ? idx : 3'd0;
endmodule

// File: tb/tb_minterm_scanner.sv
// Scoreboard bench for minterm_scanner: SETTLE=1 and SETTLE=3 instances,
// truth-table reference model, per-cycle monitor of busy/abc_out/done/results.
module tb_minterm_scanner;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start1, start3, f1, f3;
    logic [2:0] abc1, abc3, err1, err3;
    logic       busy1, busy3, done1, done3, match1, match3;
    logic [7:0] mask1, mask3;

    int checks = 0, failures = 0, cyc = 0;
    bit mon_en = 0;
    int fmode = 0;
    logic [7:0] tbl = 8'h00;
    logic [2:0] d1 = 3'd0, d2 = 3'd0;

    typedef struct {
        logic [7:0] mask;
        logic       match;
        logic [2:0] err;
        int         st;
    } exp_t;
    exp_t q1[$], q3[$];
    logic [7:0] m1_mask, m3_mask;
    logic       m1_match, m3_match;
    logic [2:0] m1_err, m3_err;

    minterm_scanner #(.EXPECTED(8'hD5), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start1), .f_in(f1), .abc_out(abc1),
        .busy(busy1), .done(done1), .mask(mask1), .match(match1), .err_idx(err1));
    minterm_scanner #(.EXPECTED(8'hD5), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .f_in(f3), .abc_out(abc3),
        .busy(busy3), .done(done3), .mask(mask3), .match(match3), .err_idx(err3));

    // Function block models: 0 = C' + AB, 1 = C', 2 = arbitrary truth table.
    function automatic logic ref_f(int mode, logic [2:0] v, logic [7:0] t);
        case (mode)
            0: return !v[0] || (v[2] && v[1]);
            1: return !v[0];
            default: return t[v];
        endcase
    endfunction

    function automatic logic [7:0] ref_mask(int mode, logic [7:0] t);
        logic [7:0] m = 8'h00;
        for (int i = 0; i < 8; i++) m[i] = ref_f(mode, 3'(i), t);
        return m;
    endfunction

    function automatic logic [2:0] low_diff(logic [7:0] a, logic [7:0] b);
        for (int i = 0; i < 8; i++) if (a[i] != b[i]) return 3'(i);
        return 3'd0;
    endfunction

    always_comb f1 = ref_f(fmode, abc1, tbl);
    // Slow block for the SETTLE=3 instance: output lags its inputs by two cycles.
    always @(posedge clk) begin
        d1 <= abc3;
        d2 <= d1;
    end
    always_comb f3 = ref_f(0, d2, 8'h00);
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(int mode, logic [7:0] t, int st);
        exp_t e;
        e.mask  = ref_mask(mode, t);
        e.match = (e.mask == 8'hD5);
        e.err   = low_diff(e.mask, 8'hD5);
        e.st    = st;
        return e;
    endfunction

    // Monitor: rel = cycles since the edge that accepted start.
    always @(negedge clk) begin
        int rel, ib;
        if (mon_en) begin
            if (q1.size() > 0) begin
                rel = cyc - q1[0].st;
                ib  = (rel >= 0 && rel < 16) ? 1 : 0;
                chk("busy1", busy1, ib);
                chk("abc1", abc1, ib ? rel / 2 : 0);
                chk("done1", done1, rel == 16 ? 1 : 0);
                if (rel == 16) begin
                    m1_mask = q1[0].mask; m1_match = q1[0].match; m1_err = q1[0].err;
                    void'(q1.pop_front());
                end
            end else begin
                chk("busy1_idle", busy1, 0);
                chk("done1_idle", done1, 0);
                chk("abc1_idle", abc1, 0);
            end
            chk("mask1", mask1, m1_mask);
            chk("match1", match1, m1_match);
            chk("err1", err1, m1_err);

            if (q3.size() > 0) begin
                rel = cyc - q3[0].st;
                ib  = (rel >= 0 && rel < 32) ? 1 : 0;
                chk("busy3", busy3, ib);
                chk("abc3", abc3, ib ? rel / 4 : 0);
                chk("done3", done3, rel == 32 ? 1 : 0);
                if (rel == 32) begin
                    m3_mask = q3[0].mask; m3_match = q3[0].match; m3_err = q3[0].err;
                    void'(q3.pop_front());
                end
            end else begin
                chk("busy3_idle", busy3, 0);
                chk("done3_idle", done3, 0);
            end
            chk("mask3", mask3, m3_mask);
            chk("match3", match3, m3_match);
            chk("err3", err3, m3_err);
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_models();
        m1_mask = 8'h00; m1_match = 1'b0; m1_err = low_diff(8'h00, 8'hD5);
        m3_mask = 8'h00; m3_match = 1'b0; m3_err = low_diff(8'h00, 8'hD5);
    endtask

    task automatic go1(int mode, logic [7:0] t);
        fmode  = mode;
        tbl    = t;
        start1 = 1'b1;
        q1.push_back(mk_exp(mode, t, cyc + 1));
        nxt();
        start1 = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q1.size() > 0 || q3.size() > 0) && n < 200) begin
            nxt();
            n++;
        end
        if (q1.size() > 0 || q3.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL timeout cyc=%0d pending1=%0d pending3=%0d", cyc, q1.size(), q3.size());
            q1.delete();
            q3.delete();
        end
        nxt();
    endtask

    initial begin
        rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0;
        repeat (3) nxt();
        reset_models();
        start1 = 1'b1;              // reset must win over start
        mon_en = 1'b1;
        nxt();
        start1 = 1'b0;
        rst_n  = 1'b1;
        nxt();

        go1(0, 8'h00); wait_idle();  // C' + AB -> D5, match
        go1(1, 8'h00); wait_idle();  // C' -> 55, err 7

        // Re-pulses during the scan must be ignored.
        go1(0, 8'h00);
        repeat (2) nxt();
        start1 = 1'b1; nxt(); start1 = 1'b0;
        repeat (6) nxt();
        start1 = 1'b1; nxt(); start1 = 1'b0;
        wait_idle();

        // Reset mid-scan: scan discarded, results back to reset values.
        go1(1, 8'h00);
        repeat (8) nxt();
        rst_n = 1'b0;
        nxt();
        q1.delete();
        reset_models();
        rst_n = 1'b1;
        repeat (3) nxt();
        go1(0, 8'h00); wait_idle();

        for (int k = 0; k < 5; k++) begin
            go1(2, 8'($urandom_range(0, 255)));
            wait_idle();
        end
        go1(2, 8'hD5); wait_idle();

        // SETTLE = 3 with a two-cycle-late function block.
        start3 = 1'b1;
        q3.push_back(mk_exp(0, 8'h00, cyc + 1));
        nxt();
        start3 = 1'b0;
        wait_idle();

        // Start held high: back-to-back scans with one IDLE cycle between.
        fmode  = 1;
        start1 = 1'b1;
        q1.push_back(mk_exp(1, 8'h00, cyc + 1));
        q1.push_back(mk_exp(1, 8'h00, cyc + 19));
        repeat (25) nxt();
        start1 = 1'b0;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/minterm_scanner.md
MINTERM_SCANNER -- requirements
Module: minterm_scanner

Purpose: sequential truth-table reader for a 3-input combinational function block; drives every input combination, reads back the single output, and reports the minterm mask against an expected mask.

Interface
REQ-001 SHALL have parameter EXPECTED, default 8'hD5, giving the expected minterm mask (bit i = output for input combination i; default = minterms 0,2,4,6,7).
REQ-002 SHALL have parameter SETTLE, default 1, giving the number of wait cycles after driving the inputs before the output is sampled (legal range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous reset, active low.
REQ-005 SHALL have port start, input, 1 bit: scan request, honoured only in IDLE.
REQ-006 SHALL have port f_in, input, 1 bit: output of the function block under test.
REQ-007 SHALL have port abc_out, output, 3 bits: drives the function inputs, A = bit 2, B = bit 1, C = bit 0.
REQ-008 SHALL have port busy, output, 1 bit: high in DRIVE and SAMPLE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port mask, output, 8 bits: last completed scan result.
REQ-011 SHALL have port match, output, 1 bit: high when mask == EXPECTED.
REQ-012 SHALL have port err_idx, output, 3 bits: lowest index i where mask[i] != EXPECTED[i], or 0 when match = 1.

Function
REQ-013 SHALL implement the FSM states IDLE, DRIVE, SAMPLE and DONE.
REQ-014 SHALL, in IDLE with start = 1, go to DRIVE with idx = 0 and settle counter = 0 on the next edge.
REQ-015 SHALL keep abc_out = idx in DRIVE and SAMPLE, and abc_out = 3'b000 in IDLE and DONE.
REQ-016 SHALL remain in DRIVE for exactly SETTLE cycles, incrementing the settle counter each cycle, then go to SAMPLE.
REQ-017 SHALL, in SAMPLE, write f_in into shadow bit idx at the edge leaving SAMPLE.
REQ-018 SHALL, on leaving SAMPLE, go to DRIVE with idx + 1 and counter cleared if idx < 7, or to DONE if idx = 7.
REQ-019 SHALL, on entry to DONE, copy shadow to mask and update match and err_idx on the same edge, so all three are valid in the DONE cycle.
REQ-020 SHALL assert done for the single DONE cycle only, and go from DONE to IDLE unconditionally.
REQ-021 SHALL give a latency, for a start sampled at edge 0, of done high in cycle 1 + 8*(SETTLE+1): cycle 17 for SETTLE = 1.
REQ-022 SHALL ignore start while busy or in DONE; it is neither queued nor restarts the scan.
REQ-023 SHALL hold mask, match and err_idx constant between DONE cycles; a scan in progress never alters them.
REQ-024 SHALL keep idx as a 3-bit value that never wraps during a scan; the 7 -> DONE transition is the only exit.
REQ-025 SHALL accept a start held high continuously, running back-to-back scans with a single IDLE cycle between DONE and the next DRIVE.

Reset
REQ-026 SHALL, when rst_n = 0 at a rising edge, force state = IDLE, idx = 0, counter = 0, shadow = 0, mask = 8'h00, match = (EXPECTED == 8'h00), err_idx = lowest set bit of EXPECTED (0 if none), abc_out = 0, busy = 0 and done = 0.
REQ-027 SHALL let reset mid-scan abort immediately, discarding the partial shadow and leaving no done pulse.
REQ-028 SHALL give reset priority over start in the same cycle.

Verification
REQ-029 SHALL cover: f_in driven by the model C' + AB, SETTLE = 1, start pulse -> abc_out steps 0..7, done in cycle 17, mask = 8'hD5, match = 1, err_idx = 0.
REQ-030 SHALL cover: model with minterm 7 removed (f_in = C') -> mask = 8'h55, match = 0, err_idx = 7.
REQ-031 SHALL cover: start re-pulsed at cycles 3 and 10 of a scan -> no restart, single done at cycle 17.
REQ-032 SHALL cover: rst_n low at cycle 9 of a scan, then start -> no done before the restart, mask unchanged from reset value 8'h00, fresh scan completes correctly.
REQ-033 SHALL cover: SETTLE = 3, f_in delayed two cycles from abc_out -> mask still 8'hD5, done at cycle 33.
REQ-034 SHALL cover: start held high -> done pulses at cycles 17 and 35, mask stable between them.
